alu_cond_stage: RTL and testbench
=================================

ALU_COND_STAGE -- requirements
Module: alu_cond_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the ALU result width.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the statistics counter width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on the clk rising edge.
REQ-005 in_valid  input  1  upstream ALU result present this cycle.
REQ-006 in_ready  output  1  block accepts the upstream word this cycle.
REQ-007 Result  input  WIDTH  ALU result.
REQ-008 ALUFlags  input  4  ALU flags ordered {N,Z,C,V}.
REQ-009 Cond  input  4  condition code of the instruction.
REQ-010 FlagWrite  input  2  bit1 enables N,Z update; bit0 enables C,V update.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_ready  input  1  downstream accepts the output word.
REQ-013 out_result  output  WIDTH  registered Result.
REQ-014 out_exec  output  1  registered condition-pass (CondEx).
REQ-015 out_flags  output  4  stored flag register {N,Z,C,V}, live value.
REQ-016 exec_count, skip_count  output  CNT_W each  accepted-and-executed / accepted-and-squashed counts.

Function
REQ-017 An input transfer SHALL occur when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-018 in_ready SHALL equal !out_valid || out_ready (combinational; one-entry pipeline register, full throughput).
REQ-019 CondEx SHALL be evaluated combinationally from Cond and the stored flags (before this word's update): 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F SHALL evaluate to 0.
REQ-020 On an input transfer with CondEx=1, N,Z SHALL load from ALUFlags[3:2] if FlagWrite[1], and C,V from ALUFlags[1:0] if FlagWrite[0]; otherwise flags SHALL hold.
REQ-021 On an input transfer with CondEx=0, flags SHALL hold regardless of FlagWrite.
REQ-022 Flag update SHALL be visible to the next accepted word (back-to-back dependence, zero bubbles).
REQ-023 On an input transfer, out_result<=Result, out_exec<=CondEx, out_valid<=1, latency one cycle.
REQ-024 Without an input transfer, an output transfer SHALL clear out_valid; otherwise out_valid and out_result/out_exec SHALL hold (stable while stalled).
REQ-025 Simultaneous input and output transfer SHALL leave out_valid=1 with the new word.
REQ-026 No flag update, counter increment or output change SHALL occur when in_valid=1 and in_ready=0.
REQ-027 exec_count SHALL increment on each input transfer with CondEx=1, skip_count on CondEx=0; both SHALL saturate at all-ones.
REQ-028 Block state SHALL be two-state: EMPTY (out_valid=0) and FULL (out_valid=1); transitions per REQ-023..025.

Reset
REQ-029 With reset=0 at a clk edge: out_valid=0, out_result=0, out_exec=0, out_flags=4'b0000, both counters=0; reset SHALL override any concurrent transfer.
REQ-030 Reset asserted mid-stall SHALL discard the held word; in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-031 Reset, then Result=5'h00, ALUFlags=4'b0100, Cond=E, FlagWrite=11 -> next cycle out_valid=1, out_exec=1, out_flags=0100, exec_count=1.
REQ-032 Following word Cond=0 (EQ), FlagWrite=11, ALUFlags=1000 -> out_exec=1, out_flags=1000; next word Cond=0 -> out_exec=0, flags stay 1000, skip_count=1.
REQ-033 out_ready=0 with out_valid=1 and in_valid=1 for 3 cycles -> in_ready=0, out_result and flags unchanged; release out_ready -> pending word accepted same cycle, no loss or duplicate.
REQ-034 FlagWrite=01, Cond=E, ALUFlags=1111 from flags 0000 -> out_flags=0011; Cond=F -> out_exec=0 always.
REQ-035 Stream 300 AL words with CNT_W=8 -> exec_count saturates at 255; reset asserted during stall -> all outputs zero next cycle.

Source files
------------

// File: rtl/alu_cond_stage.sv
// Condition-check stage: evaluates the instruction condition against the stored NZCV flags,
// applies the flag update of executed words, and registers the result behind a one-entry handshake.
module alu_cond_stage #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Result,
    input  logic [3:0]       ALUFlags,
    input  logic [3:0]       Cond,
    input  logic [1:0]       FlagWrite,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_exec,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] skip_count
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Flag vector layout is {N,Z,C,V}; code 4'hF never passes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == {CNT_W{1'b1}}) sat_inc = cnt;
        else                      sat_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exec_q, exec_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
    logic             in_xfer, out_xfer, cond_ex;

    assign out_valid  = (state_q == ST_FULL);
    assign in_ready   = !out_valid || out_ready;
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    assign cond_ex    = cond_pass(Cond, flags_q);

    assign out_result = result_q;
    assign out_exec   = exec_q;
    assign out_flags  = flags_q;
    assign exec_count = exec_cnt_q;
    assign skip_count = skip_cnt_q;

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        exec_d     = exec_q;
        flags_d    = flags_q;
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (in_xfer) begin
            state_d  = ST_FULL;
            result_d = Result;
            exec_d   = cond_ex;
            // Squashed words never touch the flags, whatever FlagWrite says.
            if (cond_ex) begin
                if (FlagWrite[1]) flags_d[3:2] = ALUFlags[3:2];
                if (FlagWrite[0]) flags_d[1:0] = ALUFlags[1:0];
                exec_cnt_d = sat_inc(exec_cnt_q);
            end else begin
                skip_cnt_d = sat_inc(skip_cnt_q);
            end
        end else if (out_xfer) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            result_q   <= '0;
            exec_q     <= 1'b0;
            flags_q    <= 4'b0000;
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            exec_q     <= exec_d;
            flags_q    <= flags_d;
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_cond_stage.sv
// Bench for alu_cond_stage: directed vectors, a behavioural reference model checked every
// cycle, and hand-computed literal expectations at key points.
module tb_alu_cond_stage;

    localparam int WIDTH = 5;
    localparam int CNT_W = 8;
    localparam int CMAX  = 255;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Result;
    logic [3:0]       ALUFlags;
    logic [3:0]       Cond;
    logic [1:0]       FlagWrite;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_exec;
    logic [3:0]       out_flags;
    logic [CNT_W-1:0] exec_count;
    logic [CNT_W-1:0] skip_count;

    int n_checks = 0;
    int n_err    = 0;

    alu_cond_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Result(Result), .ALUFlags(ALUFlags), .Cond(Cond), .FlagWrite(FlagWrite),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_exec(out_exec), .out_flags(out_flags),
        .exec_count(exec_count), .skip_count(skip_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flags as named booleans, counters as plain integers.
    bit m_init = 0;
    bit m_valid, m_exec;
    bit m_n, m_z, m_c, m_v;
    int m_res, m_ec, m_sc;

    function automatic bit passes(input logic [3:0] cc, input bit n, input bit z, input bit c, input bit v);
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit acc, p;
        if (!reset) begin
            m_init = 1; m_valid = 0; m_exec = 0; m_res = 0;
            m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_ec = 0; m_sc = 0;
        end else if (m_init) begin
            acc = in_valid && (!m_valid || out_ready);
            if (acc) begin
                p = passes(Cond, m_n, m_z, m_c, m_v);
                if (p) begin
                    if (FlagWrite[1]) begin m_n = ALUFlags[3]; m_z = ALUFlags[2]; end
                    if (FlagWrite[0]) begin m_c = ALUFlags[1]; m_v = ALUFlags[0]; end
                    if (m_ec < CMAX) m_ec++;
                end else if (m_sc < CMAX) m_sc++;
                m_valid = 1; m_res = int'(Result); m_exec = p;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            check("out_flags", 32'(out_flags), 32'({m_n, m_z, m_c, m_v}));
            check("exec_count", 32'(exec_count), 32'(m_ec));
            check("skip_count", 32'(skip_count), 32'(m_sc));
            check("out_result", 32'(out_result), 32'(m_res));
            check("out_exec", 32'(out_exec), 32'(m_exec));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [WIDTH-1:0] r, input logic [3:0] f, input logic [3:0] c, input logic [1:0] fw);
        in_valid = 1'b1; Result = r; ALUFlags = f; Cond = c; FlagWrite = fw;
    endtask

    initial begin
        logic [15:0] exp_tab;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Result = '0; ALUFlags = '0; Cond = '0; FlagWrite = '0;
        step(); step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'(out_flags), 32'd0);
        check("rst_exec_count", 32'(exec_count), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        reset = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // First AL word sets Z.
        word(5'h00, 4'b0100, 4'hE, 2'b11); step();
        check("al_valid", 32'(out_valid), 32'd1);
        check("al_exec", 32'(out_exec), 32'd1);
        check("al_flags", 32'(out_flags), 32'b0100);
        check("al_exec_count", 32'(exec_count), 32'd1);

        word(5'h01, 4'b1000, 4'h0, 2'b11); step();
        check("eq_pass_exec", 32'(out_exec), 32'd1);
        check("eq_pass_flags", 32'(out_flags), 32'b1000);
        word(5'h02, 4'b0000, 4'h0, 2'b11); step();
        check("eq_fail_exec", 32'(out_exec), 32'd0);
        check("eq_fail_flags", 32'(out_flags), 32'b1000);
        check("eq_fail_skip", 32'(skip_count), 32'd1);

        // Stall three cycles with a pending word.
        out_ready = 1'b0;
        word(5'h03, 4'b0000, 4'hE, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_result", 32'(out_result), 32'h02);
            check("stall_flags", 32'(out_flags), 32'b1000);
        end
        out_ready = 1'b1;
        step();
        check("release_result", 32'(out_result), 32'h03);
        check("release_exec_count", 32'(exec_count), 32'd3);
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_exec_count", 32'(exec_count), 32'd3);

        // C,V-only update and the never-true code.
        reset = 1'b0; step(); reset = 1'b1;
        word(5'h04, 4'b1111, 4'hE, 2'b01); step();
        check("fw01_flags", 32'(out_flags), 32'b0011);
        word(5'h05, 4'b1111, 4'hF, 2'b11); step();
        check("condF_exec", 32'(out_exec), 32'd0);
        check("condF_flags", 32'(out_flags), 32'b0011);

        // Condition table with flags N=1 Z=0 C=0 V=1.
        word(5'h06, 4'b1001, 4'hE, 2'b11); step();
        exp_tab = 16'h565A;
        for (int c = 0; c < 16; c++) begin
            word(5'(c), 4'b0110, 4'(c), 2'b00); step();
            check($sformatf("cond_tab_%0h", c), 32'(out_exec), 32'(exp_tab[c]));
        end

        // Mixed handshake pattern, checked by the model only.
        for (int i = 0; i < 80; i++) begin
            in_valid  = (i % 3) != 1;
            out_ready = (i % 4) != 2;
            Result    = 5'(i);
            ALUFlags  = 4'((i * 7) % 16);
            Cond      = 4'((i * 5) % 16);
            FlagWrite = 2'(i % 4);
            step();
        end

        // Counter saturation, then reset during a stall.
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step(); reset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            word(5'(i), 4'b0000, 4'hE, 2'b00); step();
        end
        check("sat_exec_count", 32'(exec_count), 32'd255);
        check("sat_skip_count", 32'(skip_count), 32'd0);
        out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        check("stall_rst_valid", 32'(out_valid), 32'd0);
        check("stall_rst_result", 32'(out_result), 32'd0);
        check("stall_rst_exec_count", 32'(exec_count), 32'd0);
        check("stall_rst_flags", 32'(out_flags), 32'd0);
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        check("stall_rst_in_ready", 32'(in_ready), 32'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
